string_accel: RTL and testbench

STRING_ACCEL -- requirements
Module: string_accel

---
 rtl/string_accel.sv | 182 ++++++++++++++++++
 tb/tb_string_accel.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/string_accel.sv
// rtl/string_accel.sv - string accelerator: compare, case map, reverse, strlen, count, search.
// Optional STRING_ACCEL_CASEFOLD_EN enables index 7 (case-insensitive compare).
module string_accel #(
  parameter int NCHARS = 8,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [3:0]          index,
  input  logic [CNT_W-1:0]    length,
  input  logic [NCHARS*8-1:0] A,
  input  logic [NCHARS*8-1:0] B,
  output logic                done,
  output logic                busy,
  output logic                error,
  output logic [NCHARS*8-1:0] Result
);
  localparam int W = NCHARS * 8;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_SEARCH, S_DONE} state_t;

  state_t           state_q;
  logic [3:0]       idx_q;
  logic [CNT_W-1:0] len_q, pos_q;
  logic [W-1:0]     a_q, b_q, res_q;
  logic             done_q, busy_q, err_q;

  logic [W-1:0]     exec_d;
  logic             match_d, last_pos_d, idx_ok_d;

`ifdef STRING_ACCEL_CASEFOLD_EN
  function automatic logic [7:0] fold(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5a) ? c + 8'd32 : c;
  endfunction
`endif

  // Single-cycle ops, all evaluated from the captured operands
  always_comb begin
    int len, cnt, slen;
    logic eq, found;
    logic [7:0] ak, bk, b0;
`ifdef STRING_ACCEL_CASEFOLD_EN
    logic eqf;
    eqf = 1'b1;
`endif
    len   = int'(len_q);
    cnt   = 0;
    slen  = NCHARS;
    eq    = 1'b1;
    found = 1'b0;
    b0    = b_q[W-1 -: 8];
    exec_d = a_q;
    for (int k = 0; k < NCHARS; k++) begin
      ak = a_q[(NCHARS-1-k)*8 +: 8];
      bk = b_q[(NCHARS-1-k)*8 +: 8];
      if (!found && ak == 8'h00) begin
        slen  = k;
        found = 1'b1;
      end
      if (k < len) begin
        if (ak != bk) eq = 1'b0;
        if (ak == b0) cnt = cnt + 1;
`ifdef STRING_ACCEL_CASEFOLD_EN
        if (fold(ak) != fold(bk)) eqf = 1'b0;
`endif
        case (idx_q)
          4'd1: if (ak >= 8'h61 && ak <= 8'h7a) exec_d[(NCHARS-1-k)*8 +: 8] = ak - 8'd32;
          4'd2: if (ak >= 8'h41 && ak <= 8'h5a) exec_d[(NCHARS-1-k)*8 +: 8] = ak + 8'd32;
          4'd3: exec_d[(NCHARS-1-k)*8 +: 8] = a_q[(NCHARS-len+k)*8 +: 8];
          default: ;
        endcase
      end
    end
    case (idx_q)
      4'd0: exec_d = W'(eq);
      4'd5: exec_d = W'(slen);
      4'd6: exec_d = W'(cnt);
`ifdef STRING_ACCEL_CASEFOLD_EN
      4'd7: exec_d = W'(eqf);
`endif
      default: ;
    endcase
  end

  // Search window compare at the current start position
  always_comb begin
    int p;
    match_d = 1'b1;
    for (int j = 0; j < NCHARS; j++) begin
      p = int'(pos_q) + j;
      if (j < int'(len_q)) begin
        if (p >= NCHARS) match_d = 1'b0;
        else if (a_q[(NCHARS-1-p)*8 +: 8] != b_q[(NCHARS-1-j)*8 +: 8]) match_d = 1'b0;
      end
    end
    last_pos_d = int'(pos_q) >= NCHARS - int'(len_q);
`ifdef STRING_ACCEL_CASEFOLD_EN
    idx_ok_d = 1'b1;
`else
    idx_ok_d = idx_q <= 4'd6;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      pos_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          res_q  <= '0;
          if (go) begin
            idx_q   <= index;
            len_q   <= length;
            a_q     <= A;
            b_q     <= B;
            busy_q  <= 1'b1;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          pos_q <= '0;
          if (!idx_ok_d || idx_q > 4'd7 || int'(len_q) > NCHARS || (idx_q == 4'd4 && len_q == '0)) begin
            err_q   <= 1'b1;
            res_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else if (idx_q == 4'd4) begin
            state_q <= S_SEARCH;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q   <= exec_d;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_SEARCH: begin
          if (match_d) begin
            res_q   <= W'(pos_q);
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else if (last_pos_d) begin
            res_q   <= W'(NCHARS);
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            pos_q <= pos_q + 1'b1;
          end
        end
        S_DONE: begin
          // done is shown for at least one cycle even if go already dropped
          done_q <= 1'b1;
          if (done_q && !go) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done   = done_q;
  assign busy   = busy_q;
  assign error  = err_q;
  assign Result = res_q;
endmodule

// File: tb/tb_string_accel.sv
// tb/tb_string_accel.sv - directed vector table plus randomized ops against a reference model.
module tb_string_accel;
  localparam int NC = 8;

  logic        clk = 1'b0;
  logic        reset, go;
  logic [3:0]  index;
  logic [7:0]  length;
  logic [63:0] A, B, Result;
  logic        done, busy, error;

  int total = 0;
  int bad   = 0;

  string_accel #(.NCHARS(NC), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .go(go), .index(index), .length(length),
    .A(A), .B(B), .done(done), .busy(busy), .error(error), .Result(Result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  idx;
    logic [7:0]  len;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        err;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model(input logic [3:0] idx, input logic [7:0] len, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output logic err,
                       output int lat);
    byte unsigned ac[NC], bc[NC], oc[NC];
    int n, hits;
    bit valid, ok;
    n = int'(len);
    for (int k = 0; k < NC; k++) begin
      ac[k] = a[(NC-1-k)*8 +: 8];
      bc[k] = b[(NC-1-k)*8 +: 8];
      oc[k] = ac[k];
    end
`ifdef STRING_ACCEL_CASEFOLD_EN
    valid = idx <= 4'd7;
`else
    valid = idx <= 4'd6;
`endif
    res = '0; err = 1'b0; lat = 3;
    if (!valid || n > NC || (idx == 4'd4 && n == 0)) begin
      err = 1'b1; lat = 2;
      return;
    end
    case (idx)
      4'd0, 4'd7: begin
        ok = 1;
        for (int k = 0; k < n; k++) begin
          byte unsigned x, y;
          x = ac[k]; y = bc[k];
          if (idx == 4'd7) begin
            if (x >= 65 && x <= 90) x = x + 32;
            if (y >= 65 && y <= 90) y = y + 32;
          end
          if (x != y) ok = 0;
        end
        res = ok ? 64'd1 : 64'd0;
      end
      4'd1, 4'd2, 4'd3: begin
        for (int k = 0; k < n; k++) begin
          if (idx == 4'd1 && ac[k] >= 97 && ac[k] <= 122) oc[k] = ac[k] - 32;
          if (idx == 4'd2 && ac[k] >= 65 && ac[k] <= 90) oc[k] = ac[k] + 32;
          if (idx == 4'd3) oc[k] = ac[n-1-k];
        end
        for (int k = 0; k < NC; k++) res[(NC-1-k)*8 +: 8] = oc[k];
      end
      4'd4: begin
        res = 64'(NC);
        lat = (NC - n + 1) + 2;
        for (int p = NC - n; p >= 0; p--) begin
          ok = 1;
          for (int j = 0; j < n; j++) if (ac[p+j] != bc[j]) ok = 0;
          if (ok) begin res = 64'(p); lat = p + 3; end
        end
      end
      4'd5: begin
        res = 64'(NC);
        for (int k = NC - 1; k >= 0; k--) if (ac[k] == 0) res = 64'(k);
      end
      4'd6: begin
        hits = 0;
        for (int k = 0; k < n; k++) if (ac[k] == bc[0]) hits++;
        res = 64'(hits);
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input string nm, input logic [3:0] i, input logic [7:0] l,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_res,
                        input logic exp_err, input int exp_lat, input bit drop_go);
    int c;
    bit both;
    @(negedge clk);
    index = i; length = l; A = a; B = b; go = 1'b1;
    @(posedge clk); #1;
    index = i ^ 4'h5; length = l + 8'd3; A = ~a; B = ~b;
    if (drop_go) go = 1'b0;
    c = 0; both = 0;
    while (!done && c < 40) begin
      @(posedge clk); #1;
      c++;
      if (busy && done) both = 1;
    end
    chk({nm, " latency"}, 64'(c), 64'(exp_lat));
    chk({nm, " result"}, Result, exp_res);
    chk({nm, " error"}, {63'd0, error}, {63'd0, exp_err});
    chk({nm, " busy&done"}, {63'd0, both}, 64'd0);
    if (!drop_go) begin
      @(posedge clk); #1;
      chk({nm, " hold"}, {done, error, Result[61:0]}, {1'b1, exp_err, exp_res[61:0]});
    end
    go = 1'b0;
    @(posedge clk); #1;
    chk({nm, " clear"}, {done, error, busy, Result[60:0]}, 64'd0);
  endtask

  vec_t tv[13];
  string alpha = "abAB z";

  initial begin
    logic [63:0] er, ra, rb;
    logic ee;
    int el, off;
    byte unsigned ch;

    tv[0]  = '{4'd1, 8'd5, "hello wo", 64'd0, "HELLO wo", 1'b0, 3};
    tv[1]  = '{4'd3, 8'd4, "abcdefgh", 64'd0, "dcbaefgh", 1'b0, 3};
    tv[2]  = '{4'd4, 8'd3, "xxabcabc", "abc.....", 64'd2, 1'b0, 5};
    tv[3]  = '{4'd4, 8'd3, "xxabcabc", "zzz.....", 64'd8, 1'b0, 8};
    tv[4]  = '{4'd9, 8'd3, "xxabcabc", "abc.....", 64'd0, 1'b1, 2};
    tv[5]  = '{4'd0, 8'd9, "xxabcabc", "xxabcabc", 64'd0, 1'b1, 2};
`ifdef STRING_ACCEL_CASEFOLD_EN
    tv[6]  = '{4'd7, 8'd5, "HeLLo...", "hello...", 64'd1, 1'b0, 3};
`else
    tv[6]  = '{4'd7, 8'd5, "HeLLo...", "hello...", 64'd0, 1'b1, 2};
`endif
    tv[7]  = '{4'd2, 8'd8, "ABCD1234", 64'd0, "abcd1234", 1'b0, 3};
    tv[8]  = '{4'd5, 8'd0, {"abc", 8'h00, "defg"}, 64'd0, 64'd3, 1'b0, 3};
    tv[9]  = '{4'd6, 8'd8, "abacabaa", "a.......", 64'd5, 1'b0, 3};
    tv[10] = '{4'd0, 8'd3, "abcXXXXX", "abcYYYYY", 64'd1, 1'b0, 3};
    tv[11] = '{4'd4, 8'd0, "abcXXXXX", "abcYYYYY", 64'd0, 1'b1, 2};
    tv[12] = '{4'd4, 8'd8, "abcdefgh", "abcdefgh", 64'd0, 1'b0, 3};

    reset = 1'b1; go = 1'b0; index = '0; length = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", {done, busy, error, Result[60:0]}, 64'd0);
    @(negedge clk); reset = 1'b0;

    for (int t = 0; t < 13; t++)
      run_op($sformatf("vec%0d", t), tv[t].idx, tv[t].len, tv[t].a, tv[t].b,
             tv[t].res, tv[t].err, tv[t].lat, t == 1);

    // Reset lands mid-search while go is still asserted
    @(negedge clk);
    index = 4'd4; length = 8'd1; A = "aaaaaaab"; B = "b......."; go = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("reset mid-search", {done, busy, error, Result[60:0]}, 64'd0);
    @(posedge clk); #1;
    chk("reset beats go", {62'd0, busy, done}, 64'd0);
    @(negedge clk); reset = 1'b0; go = 1'b0;
    run_op("after reset", 4'd4, 8'd1, "aaaaaaab", "b.......", 64'd7, 1'b0, 10, 1'b0);

    for (int r = 0; r < 150; r++) begin
      for (int k = 0; k < NC; k++) begin
        ch = (($urandom_range(0, 6) == 6) ? 8'h00 : alpha[$urandom_range(0, 5)]);
        ra[(NC-1-k)*8 +: 8] = ch;
        rb[(NC-1-k)*8 +: 8] = alpha[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 1) == 1) begin
        off = $urandom_range(0, NC - 1);
        for (int k = 0; k + off < NC; k++) rb[(NC-1-k)*8 +: 8] = ra[(NC-1-k-off)*8 +: 8];
      end
      index  = 4'($urandom_range(0, 9));
      length = 8'($urandom_range(0, 9));
      model(index, length, ra, rb, er, ee, el);
      run_op($sformatf("rand%0d", r), index, length, ra, rb, er, ee, el, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
